mem_wb_skid_stage: RTL and testbench
====================================

Name: mem_wb_skid_stage

Overview:
Parametrised MEM->WB pipeline register for a multi-lane write-back path. It has LANES register-write lanes per entry. It replaces the plain stall-driven latch with a valid/ready handshake and a 2-entry skid buffer, so back-pressure from WB never forces a combinational ready path into MEM. It adds a synchronous flush, x0-write squashing, and a forwarding lookup over buffered, not-yet-retired writes. It sits between MEM and the register-file write port(s).

Parameters:
LANES, 1, number of write-back lanes per entry (1..4)
DATA_W, 32, write data width
IDX_W, 5, register index width
SQUASH_X0, 1, when 1 a lane write to index 0 has its enable cleared at capture

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; when 0 the block holds all state and performs no transfers
flush_in  input  1  synchronous flush; drops all buffered entries
in_valid_in  input  1  MEM presents an entry
in_ready_out  output  1  block can accept an entry; registered
rdE_in  input  LANES  per-lane write enable
rdIdx_in  input  LANES*IDX_W  per-lane destination index, lane 0 in the LSBs
rdData_in  input  LANES*DATA_W  per-lane write data, lane 0 in the LSBs
out_valid_out  output  1  head entry valid
out_ready_in  input  1  WB consumes the head entry
rdE_out  output  LANES  head write enables; 0 when not valid
rdIdx_out  output  LANES*IDX_W  head indices; 0 when not valid
rdData_out  output  LANES*DATA_W  head data; 0 when not valid
fwd_idx_in  input  IDX_W  forwarding lookup index
fwd_hit_out  output  1  a buffered entry writes fwd_idx_in
fwd_data_out  output  DATA_W  forwarded data; 0 on miss
count_out  output  2  occupancy, 0..2

Behaviour:
- Storage: main entry (head) and skid entry. Each entry holds a valid bit, LANES enables, indices and data.
- Reset (rst_in=0, asynchronous): both valid bits 0 and all stored fields 0. Outputs: in_ready_out=1, out_valid_out=0, rdE/rdIdx/rdData_out=0, count_out=0, fwd_hit_out=0, fwd_data_out=0.
- Accept: accept = rdy_in & in_valid_in & in_ready_out. Pop: pop = rdy_in & out_valid_out & out_ready_in.
- Capture rule: if SQUASH_X0=1, a lane with idx==0 is stored with enable 0. Its index and data are stored unchanged.
- Next-state rules, evaluated when rdy_in=1 and flush_in=0:
  - empty + accept: the entry goes to main; out_valid_out=1 next cycle. Latency is 1 cycle.
  - main only, accept and pop: the new entry replaces main; count stays 1.
  - main only, accept, no pop: the new entry goes to skid; count becomes 2 and in_ready_out=0 next cycle.
  - main only, pop, no accept: the stage becomes empty.
  - full (in_ready_out=0), so no accept is possible: on pop, skid moves to main, skid is cleared, and in_ready_out=1 next cycle.
- in_ready_out is registered and equals !skid_valid. It never depends combinationally on out_ready_in.
- flush_in=1 with rdy_in=1: both entries are invalidated at the edge. Any same-cycle accept is discarded and any pop is ignored. Next cycle: count_out=0, in_ready_out=1. Flush has priority over every other event.
- rdy_in=0: no state change, including no flush. Outputs keep showing the current state.
- Head outputs: the main entry's fields gated by out_valid_out. Any field of an invalid head reads as zero (bubble).
- Ordering: strict FIFO. An entry never overtakes an older one.
- Forwarding is combinational over valid entries only, considering only lanes with stored enable=1 and idx==fwd_idx_in:
  - Priority: skid (newer) before main; within an entry, the higher lane index wins.
  - fwd_idx_in==0 always misses when SQUASH_X0=1.
  - A flush or pop takes effect on forwarding only after the clock edge.
- count_out = main_valid + skid_valid.
- Reset asserted mid-operation clears everything immediately (asynchronous), regardless of rdy_in.
- Invariant: skid_valid implies main_valid. The bench asserts this every cycle.

Test Plan:
- Reset, then a single entry LANES=2 {lane0: E=1,idx=3,data=0xAAAA0001; lane1: E=1,idx=7,data=0x0000BEEF} with out_ready_in=1 -> out_valid_out=1 exactly 1 cycle after accept with matching fields; out_valid_out=0 and all head fields 0 on the next cycle.
- out_ready_in=0, push entries A then B -> count_out=2, in_ready_out=0 in the cycle after B. Raise out_ready_in -> A popped, then B; in_ready_out=1 the cycle after A's pop; no loss or reorder.
- Back-to-back streaming with out_ready_in=1 and in_valid_in=1 for 8 cycles (data 1..8) -> one pop per cycle in order, count_out stays 1.
- Stage full, assert flush_in together with in_valid_in=1 (data 0x55) -> next cycle count_out=0, out_valid_out=0, in_ready_out=1; 0x55 never appears at the output.
- Forwarding: main {idx 5, data 0x11}, skid {lane0 idx 5 data 0x22, lane1 idx 5 data 0x33}, fwd_idx_in=5 -> hit=1, data=0x33. Then fwd_idx_in=0 with a lane-0 write to idx 0 stored -> hit=0, data=0, and the head shows that lane with rdE_out=0.
- rdy_in=0 for 3 cycles while in_valid_in=1 and out_ready_in=1 -> count_out and all outputs unchanged. Pull rst_in low mid-cycle -> outputs go to reset values before the next clock edge.

Source files
------------

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with a valid/ready handshake and a two-entry skid buffer.
// The head (main) entry drives the write-back lanes. The skid entry absorbs one extra
// entry so that in_ready_out is always taken straight from a flop. Buffered writes that
// have not yet retired can be looked up for forwarding.
module mem_wb_skid_stage #(
  parameter int LANES     = 1,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 5,
  parameter int SQUASH_X0 = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    in_valid_in,
  output logic                    in_ready_out,
  input  logic [LANES-1:0]        rdE_in,
  input  logic [LANES*IDX_W-1:0]  rdIdx_in,
  input  logic [LANES*DATA_W-1:0] rdData_in,
  output logic                    out_valid_out,
  input  logic                    out_ready_in,
  output logic [LANES-1:0]        rdE_out,
  output logic [LANES*IDX_W-1:0]  rdIdx_out,
  output logic [LANES*DATA_W-1:0] rdData_out,
  input  logic [IDX_W-1:0]        fwd_idx_in,
  output logic                    fwd_hit_out,
  output logic [DATA_W-1:0]       fwd_data_out,
  output logic [1:0]              count_out
);

  logic                    main_valid;
  logic [LANES-1:0]        main_e;
  logic [LANES*IDX_W-1:0]  main_idx;
  logic [LANES*DATA_W-1:0] main_data;

  logic                    skid_valid;
  logic [LANES-1:0]        skid_e;
  logic [LANES*IDX_W-1:0]  skid_idx;
  logic [LANES*DATA_W-1:0] skid_data;

  logic                    in_ready_q;
  logic [LANES-1:0]        cap_e;
  logic                    accept;
  logic                    pop;

  assign in_ready_out = in_ready_q;
  assign accept       = rdy_in & in_valid_in & in_ready_q;
  assign pop          = rdy_in & main_valid & out_ready_in;

  // Enables as they will be stored: writes to x0 lose their enable when squashing is on
  always_comb begin
    cap_e = rdE_in;
    for (int l = 0; l < LANES; l++) begin
      if ((SQUASH_X0 != 0) && (rdIdx_in[l*IDX_W +: IDX_W] == '0)) begin
        cap_e[l] = 1'b0;
      end
    end
  end

  // Two-entry buffer update; flush beats everything, and nothing moves while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      main_valid <= 1'b0;
      main_e     <= '0;
      main_idx   <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_e     <= '0;
      skid_idx   <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else if (rdy_in) begin
      if (flush_in) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (!main_valid) begin
        if (accept) begin
          main_valid <= 1'b1;
          main_e     <= cap_e;
          main_idx   <= rdIdx_in;
          main_data  <= rdData_in;
        end
      end else if (!skid_valid) begin
        if (accept && pop) begin
          main_e    <= cap_e;
          main_idx  <= rdIdx_in;
          main_data <= rdData_in;
        end else if (accept) begin
          skid_valid <= 1'b1;
          skid_e     <= cap_e;
          skid_idx   <= rdIdx_in;
          skid_data  <= rdData_in;
          in_ready_q <= 1'b0;
        end else if (pop) begin
          main_valid <= 1'b0;
        end
      end else if (pop) begin
        main_e     <= skid_e;
        main_idx   <= skid_idx;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_e     <= '0;
        skid_idx   <= '0;
        skid_data  <= '0;
        in_ready_q <= 1'b1;
      end
    end
  end

  assign out_valid_out = main_valid;
  assign rdE_out       = main_valid ? main_e    : '0;
  assign rdIdx_out     = main_valid ? main_idx  : '0;
  assign rdData_out    = main_valid ? main_data : '0;
  assign count_out     = {1'b0, main_valid} + {1'b0, skid_valid};

  // Forwarding lookup: later matches override earlier ones, so skid beats main and higher lanes win
  always_comb begin
    fwd_hit_out  = 1'b0;
    fwd_data_out = '0;
    for (int l = 0; l < LANES; l++) begin
      if (main_valid && main_e[l] && (main_idx[l*IDX_W +: IDX_W] == fwd_idx_in)) begin
        fwd_hit_out  = 1'b1;
        fwd_data_out = main_data[l*DATA_W +: DATA_W];
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (skid_valid && skid_e[l] && (skid_idx[l*IDX_W +: IDX_W] == fwd_idx_in)) begin
        fwd_hit_out  = 1'b1;
        fwd_data_out = skid_data[l*DATA_W +: DATA_W];
      end
    end
    if ((SQUASH_X0 != 0) && (fwd_idx_in == '0)) begin
      fwd_hit_out  = 1'b0;
      fwd_data_out = '0;
    end
  end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Scoreboard bench for mem_wb_skid_stage with two lanes. Directed stimulus queues the
// entries it expects to see at the head. An independent monitor compares and retires them.
module tb_mem_wb_skid_stage;
  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;

  logic                    clk_in;
  logic                    rst_in;
  logic                    rdy_in;
  logic                    flush_in;
  logic                    in_valid_in;
  logic                    in_ready_out;
  logic [LANES-1:0]        rdE_in;
  logic [LANES*IDX_W-1:0]  rdIdx_in;
  logic [LANES*DATA_W-1:0] rdData_in;
  logic                    out_valid_out;
  logic                    out_ready_in;
  logic [LANES-1:0]        rdE_out;
  logic [LANES*IDX_W-1:0]  rdIdx_out;
  logic [LANES*DATA_W-1:0] rdData_out;
  logic [IDX_W-1:0]        fwd_idx_in;
  logic                    fwd_hit_out;
  logic [DATA_W-1:0]       fwd_data_out;
  logic [1:0]              count_out;

  typedef logic [75:0] ent_t;
  ent_t expQ[$];
  int vectors = 0;
  int miscompares = 0;

  mem_wb_skid_stage #(.LANES(LANES), .DATA_W(DATA_W), .IDX_W(IDX_W), .SQUASH_X0(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
    .rdE_in(rdE_in), .rdIdx_in(rdIdx_in), .rdData_in(rdData_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .rdE_out(rdE_out), .rdIdx_out(rdIdx_out), .rdData_out(rdData_out),
    .fwd_idx_in(fwd_idx_in), .fwd_hit_out(fwd_hit_out), .fwd_data_out(fwd_data_out),
    .count_out(count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] e,
                               input logic [4:0] i0, input logic [4:0] i1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic oRdy, input logic expAccept);
    in_valid_in  = v;
    rdE_in       = e;
    rdIdx_in     = {i1, i0};
    rdData_in    = {d1, d0};
    out_ready_in = oRdy;
    if (expAccept) expQ.push_back({e & {i1 != 5'd0, i0 != 5'd0}, i1, i0, d1, d0});
    step();
  endtask

  task automatic idle(input logic oRdy);
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, oRdy, 1'b0);
  endtask

  // Monitor: check the head against the oldest expected entry and retire it on a real pop
  always @(negedge clk_in) begin
    if (rst_in) begin
      checkOutput("invariant", {127'd0, dut.skid_valid & ~dut.main_valid}, 128'd0);
      if (out_valid_out) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_head: got %0h expected none", {rdE_out, rdIdx_out, rdData_out});
        end else begin
          checkOutput("head", {rdE_out, rdIdx_out, rdData_out}, expQ[0]);
          if (rdy_in && !flush_in && out_ready_in) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; in_valid_in = 1'b0;
    rdE_in = '0; rdIdx_in = '0; rdData_in = '0; out_ready_in = 1'b0; fwd_idx_in = '0;
    step();
    step();
    checkOutput("rst_in_ready", in_ready_out, 1);
    checkOutput("rst_out_valid", out_valid_out, 0);
    checkOutput("rst_count", count_out, 0);
    checkOutput("rst_fwd_hit", fwd_hit_out, 0);
    checkOutput("rst_head", {rdE_out, rdIdx_out, rdData_out}, 0);
    rst_in = 1'b1;
    step();

    $display("[TB] single entry");
    applyStimulus(1'b1, 2'b11, 5'd3, 5'd7, 32'hAAAA0001, 32'h0000BEEF, 1'b1, 1'b1);
    checkOutput("t1_valid", out_valid_out, 1);
    checkOutput("t1_rdE", rdE_out, 2'b11);
    checkOutput("t1_rdIdx", rdIdx_out, {5'd7, 5'd3});
    checkOutput("t1_rdData", rdData_out, {32'h0000BEEF, 32'hAAAA0001});
    idle(1'b1);
    checkOutput("t1_bubble_valid", out_valid_out, 0);
    checkOutput("t1_bubble_head", {rdE_out, rdIdx_out, rdData_out}, 0);

    $display("[TB] fill and drain");
    applyStimulus(1'b1, 2'b01, 5'd1, 5'd0, 32'hA, 32'd0, 1'b0, 1'b1);
    checkOutput("t2_count_a", count_out, 1);
    applyStimulus(1'b1, 2'b01, 5'd2, 5'd0, 32'hB, 32'd0, 1'b0, 1'b1);
    checkOutput("t2_count_full", count_out, 2);
    checkOutput("t2_ready_full", in_ready_out, 0);
    applyStimulus(1'b1, 2'b01, 5'd3, 5'd0, 32'hC, 32'd0, 1'b0, 1'b0);
    checkOutput("t2_count_blocked", count_out, 2);
    idle(1'b1);
    checkOutput("t2_count_after_a", count_out, 1);
    checkOutput("t2_ready_after_a", in_ready_out, 1);
    idle(1'b1);
    checkOutput("t2_count_after_b", count_out, 0);

    $display("[TB] streaming");
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 2'b01, 5'd1, 5'd0, k, 32'd0, 1'b1, 1'b1);
      checkOutput("t3_count", count_out, 1);
    end
    idle(1'b1);
    checkOutput("t3_count_end", count_out, 0);

    $display("[TB] flush");
    applyStimulus(1'b1, 2'b01, 5'd4, 5'd0, 32'hA2, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b01, 5'd4, 5'd0, 32'hB2, 32'd0, 1'b0, 1'b1);
    flush_in = 1'b1;
    applyStimulus(1'b1, 2'b01, 5'd4, 5'd0, 32'h55, 32'd0, 1'b1, 1'b0);
    expQ.delete();
    flush_in = 1'b0;
    checkOutput("t4_count", count_out, 0);
    checkOutput("t4_valid", out_valid_out, 0);
    checkOutput("t4_ready", in_ready_out, 1);
    idle(1'b1);
    idle(1'b1);
    checkOutput("t4_valid_later", out_valid_out, 0);

    $display("[TB] forwarding");
    applyStimulus(1'b1, 2'b01, 5'd5, 5'd9, 32'h11, 32'h99, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b11, 5'd5, 5'd5, 32'h22, 32'h33, 1'b0, 1'b1);
    fwd_idx_in = 5'd5; #1;
    checkOutput("t5_hit_skid", fwd_hit_out, 1);
    checkOutput("t5_data_skid", fwd_data_out, 32'h33);
    fwd_idx_in = 5'd9; #1;
    checkOutput("t5_hit_disabled", fwd_hit_out, 0);
    checkOutput("t5_data_disabled", fwd_data_out, 0);
    fwd_idx_in = 5'd5;
    idle(1'b1);
    checkOutput("t5_hit_after_pop", fwd_hit_out, 1);
    checkOutput("t5_data_after_pop", fwd_data_out, 32'h33);
    idle(1'b1);
    checkOutput("t5_hit_empty", fwd_hit_out, 0);
    applyStimulus(1'b1, 2'b11, 5'd0, 5'd4, 32'h77, 32'h44, 1'b0, 1'b1);
    fwd_idx_in = 5'd0; #1;
    checkOutput("t5_hit_x0", fwd_hit_out, 0);
    checkOutput("t5_data_x0", fwd_data_out, 0);
    checkOutput("t5_rdE_x0", rdE_out, 2'b10);
    checkOutput("t5_rdIdx_x0", rdIdx_out, {5'd4, 5'd0});
    checkOutput("t5_rdData_x0", rdData_out, {32'h44, 32'h77});
    fwd_idx_in = 5'd4; #1;
    checkOutput("t5_hit_lane1", fwd_hit_out, 1);
    checkOutput("t5_data_lane1", fwd_data_out, 32'h44);
    idle(1'b1);
    idle(1'b0);

    $display("[TB] global stall and async reset");
    applyStimulus(1'b1, 2'b01, 5'd2, 5'd0, 32'hA6, 32'd0, 1'b0, 1'b1);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 2'b01, 5'd3, 5'd0, 32'hBB, 32'd0, 1'b1, 1'b0);
      checkOutput("t6_count", count_out, 1);
      checkOutput("t6_valid", out_valid_out, 1);
      checkOutput("t6_data", rdData_out, {32'd0, 32'hA6});
      checkOutput("t6_ready", in_ready_out, 1);
    end
    #2;
    rst_in = 1'b0;
    expQ.delete();
    #1;
    checkOutput("t6_rst_valid", out_valid_out, 0);
    checkOutput("t6_rst_count", count_out, 0);
    checkOutput("t6_rst_ready", in_ready_out, 1);
    checkOutput("t6_rst_head", {rdE_out, rdIdx_out, rdData_out}, 0);
    checkOutput("t6_rst_fwd", {fwd_hit_out, fwd_data_out}, 0);
    in_valid_in = 1'b0;
    out_ready_in = 1'b0;
    step();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle(1'b0);
    checkOutput("t6_count_after", count_out, 0);

    step();
    checkOutput("queue_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
